// File: rtl/stage_enable_sequencer.sv
// rtl/stage_enable_sequencer.sv - per-sample stage enable sequencer with ready timeout and frame accounting
module stage_enable_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 13,
    parameter int WAIT_W     = 10,
    parameter int PULSE_W    = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                         clk_operation,
    input  logic                         rst,
    input  logic                         run,
    input  logic [CNT_W-1:0]             sampling_cycle_counter,
    input  logic [NUM_STAGES*WAIT_W-1:0] stage_delay,
    input  logic [NUM_STAGES-1:0]        stage_hold,
    input  logic [NUM_STAGES-1:0]        stage_ready,
    output logic [NUM_STAGES-1:0]        enable,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         timeout_err,
    output logic [NUM_STAGES-1:0]        stage_fault,
    output logic                         overrun,
    output logic [15:0]                  frame_count
);
    localparam int IDX_W  = $clog2(NUM_STAGES);
    localparam int PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [2:0] {IDLE, DELAY, WAIT_RDY, PULSE, DONE} state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n, ld_idx;
    logic [WAIT_W-1:0]   dly, dly_n;
    logic [15:0]         tcnt, tcnt_n;
    logic [PCNT_W-1:0]   pcnt, pcnt_n;
    logic [NUM_STAGES-1:0] enable_n, fault_n;
    logic                frame_done_n, timeout_err_n, overrun_n, busy_n;
    logic [15:0]         count_n;
    logic                prev_zero, cnt_zero, trig, start;
    logic [WAIT_W-1:0]   dly_cfg [NUM_STAGES];

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            dly_cfg[i] = stage_delay[i*WAIT_W +: WAIT_W];
        end
    end

    assign cnt_zero = (sampling_cycle_counter == '0);
    assign trig     = run & cnt_zero & ~prev_zero;

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        dly_n         = dly;
        tcnt_n        = tcnt;
        pcnt_n        = pcnt;
        enable_n      = enable;
        fault_n       = stage_fault;
        overrun_n     = overrun;
        count_n       = frame_count;
        frame_done_n  = 1'b0;
        timeout_err_n = 1'b0;
        start         = 1'b0;
        ld_idx        = '0;

        if (!run) begin
            state_n  = IDLE;
            enable_n = '0;
            idx_n    = '0;
            dly_n    = '0;
            tcnt_n   = '0;
            pcnt_n   = '0;
        end else begin
            // a frame start that lands mid-sequence is dropped, only flagged
            if (trig && (state == DELAY || state == WAIT_RDY || state == PULSE)) begin
                overrun_n = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trig) start = 1'b1;
                end
                DELAY: begin
                    dly_n = dly - WAIT_W'(1);
                    if (dly == WAIT_W'(1)) state_n = WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (idx == '0 || stage_ready[idx - IDX_W'(1)]) begin
                        state_n       = PULSE;
                        tcnt_n        = '0;
                        pcnt_n        = '0;
                        enable_n[idx] = 1'b1;
                    end else if (tcnt == 16'(TIMEOUT - 1)) begin
                        state_n       = IDLE;
                        fault_n[idx]  = 1'b1;
                        timeout_err_n = 1'b1;
                        enable_n      = '0;
                        tcnt_n        = '0;
                        idx_n         = '0;
                    end else begin
                        tcnt_n = tcnt + 16'd1;
                    end
                end
                PULSE: begin
                    if (pcnt == PCNT_W'(PULSE_W - 1)) begin
                        enable_n[idx] = stage_hold[idx];
                        if (idx == IDX_W'(NUM_STAGES - 1)) begin
                            state_n      = DONE;
                            frame_done_n = 1'b1;
                            count_n      = frame_count + 16'd1;
                        end else begin
                            start  = 1'b1;
                            ld_idx = idx + IDX_W'(1);
                        end
                    end else begin
                        pcnt_n = pcnt + PCNT_W'(1);
                    end
                end
                DONE: begin
                    idx_n   = '0;
                    state_n = IDLE;
                    if (trig) start = 1'b1;
                end
                default: state_n = IDLE;
            endcase

            // shared stage entry: zero delay skips straight to the ready check
            if (start) begin
                idx_n   = ld_idx;
                dly_n   = dly_cfg[ld_idx];
                tcnt_n  = '0;
                state_n = (dly_cfg[ld_idx] != '0) ? DELAY : WAIT_RDY;
            end
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dly         <= '0;
            tcnt        <= '0;
            pcnt        <= '0;
            prev_zero   <= 1'b0;
            enable      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            stage_fault <= '0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dly         <= dly_n;
            tcnt        <= tcnt_n;
            pcnt        <= pcnt_n;
            prev_zero   <= cnt_zero;
            enable      <= enable_n;
            busy        <= busy_n;
            frame_done  <= frame_done_n;
            timeout_err <= timeout_err_n;
            stage_fault <= fault_n;
            overrun     <= overrun_n;
            frame_count <= count_n;
        end
    end
endmodule

// File: tb/tb_stage_enable_sequencer.sv
// tb/tb_stage_enable_sequencer.sv - self-checking bench for stage_enable_sequencer
module tb_stage_enable_sequencer;
    localparam int NS = 5;
    localparam int CW = 13;
    localparam int WW = 10;
    localparam int PW = 2;
    localparam int TO = 1023;

    logic            clk = 1'b0;
    logic            rst, run;
    logic [CW-1:0]   cnt;
    logic [NS*WW-1:0] stage_delay;
    logic [NS-1:0]   hold, ready;
    logic [NS-1:0]   enable, stage_fault;
    logic            busy, frame_done, timeout_err, overrun;
    logic [15:0]     frame_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int k0 = 0;
    bit chk_en = 0;
    int dly_tab [NS] = '{0, 25, 0, 130, 2};

    stage_enable_sequencer #(
        .NUM_STAGES(NS), .CNT_W(CW), .WAIT_W(WW), .PULSE_W(PW), .TIMEOUT(TO)
    ) dut (
        .clk_operation(clk), .rst(rst), .run(run), .sampling_cycle_counter(cnt),
        .stage_delay(stage_delay), .stage_hold(hold), .stage_ready(ready),
        .enable(enable), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
        .stage_fault(stage_fault), .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame-timeline model: on each accepted trigger it computes the cycle
    // of every pulse, the DONE cycle or the abort cycle, assuming stage_ready
    // stays constant for the frame.
    bit              active = 0;
    int              done_cyc = -1, abort_cyc = -1, abort_stage = 0;
    int              ps [NS];
    logic [NS-1:0]   m_held = '0, m_fault = '0, exp_en = '0;
    bit              m_over = 0, m_prevz = 0, exp_busy = 0, exp_fd = 0, exp_te = 0;
    logic [15:0]     m_count = '0;

    task automatic schedule(input int f);
        int c;
        active = 1; done_cyc = -1; abort_cyc = -1;
        for (int i = 0; i < NS; i++) ps[i] = -1;
        c = f;
        for (int i = 0; i < NS; i++) begin
            int w;
            w = c + dly_tab[i];
            if (i > 0 && !ready[i-1]) begin
                abort_cyc   = w + TO;
                abort_stage = i;
                return;
            end
            ps[i] = w + 1;
            c = ps[i] + PW;
        end
        done_cyc = c;
    endtask

    always @(posedge clk) begin : model
        int  e;
        bit  trig, in_busy;
        cyc = cyc + 1;
        e = cyc - 1;
        if (rst) begin
            active = 0; m_held = '0; m_fault = '0; m_over = 0; m_count = '0; m_prevz = 0;
            exp_en = '0; exp_busy = 0; exp_fd = 0; exp_te = 0;
        end else begin
            trig    = run && (cnt == '0) && !m_prevz;
            m_prevz = (cnt == '0);
            in_busy = active && ((done_cyc >= 0) ? (e < done_cyc) : (e < abort_cyc));
            if (!run) begin
                active = 0;
                m_held = '0;
            end else if (trig) begin
                if (in_busy) m_over = 1;
                else schedule(e + 1);
            end
            exp_te = 0;
            exp_fd = 0;
            if (active && done_cyc < 0 && cyc == abort_cyc) begin
                m_held = '0;
                m_fault[abort_stage] = 1'b1;
                exp_te = 1;
            end
            if (active && cyc == done_cyc) begin
                exp_fd = 1;
                m_count = m_count + 16'd1;
            end
            for (int i = 0; i < NS; i++) begin
                if (active && ps[i] >= 0 && cyc == ps[i] + PW && hold[i]) m_held[i] = 1'b1;
            end
            for (int i = 0; i < NS; i++) begin
                exp_en[i] = m_held[i] | (active && ps[i] >= 0 && cyc >= ps[i] && cyc < ps[i] + PW);
            end
            exp_busy = active && ((done_cyc >= 0) ? (cyc <= done_cyc) : (cyc < abort_cyc));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_enable", 32'(enable), 32'(exp_en));
            check("m_busy", 32'(busy), 32'(exp_busy));
            check("m_frame_done", 32'(frame_done), 32'(exp_fd));
            check("m_timeout_err", 32'(timeout_err), 32'(exp_te));
            check("m_stage_fault", 32'(stage_fault), 32'(m_fault));
            check("m_overrun", 32'(overrun), 32'(m_over));
            check("m_frame_count", 32'(frame_count), 32'(m_count));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < k0 + c) step();
    endtask

    task automatic trigger();
        cnt = '0;
        k0 = cyc;
        step();
        cnt = CW'(1);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        rst = 1'b1; run = 1'b0; cnt = CW'(1); hold = 5'b10000; ready = '1;
        for (int i = 0; i < NS; i++) stage_delay[i*WW +: WW] = WW'(dly_tab[i]);
        step(); step();
        chk_en = 1;
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(frame_count), 32'h0);
        check("rst_flags", {overrun, timeout_err, frame_done, stage_fault}, 32'h0);
        rst = 1'b0; run = 1'b1;
        step(); step();

        // normal frame, ready tied high
        trigger();
        at(1);   check("a_en_k1", 32'(enable), 32'h00);
        at(2);   check("a_en_k2", 32'(enable), 32'h01);
        at(3);   check("a_en_k3", 32'(enable), 32'h01);
        at(4);   check("a_en_k4", 32'(enable), 32'h00);
        at(29);  check("a_en_k29", 32'(enable), 32'h00);
        at(30);  check("a_en_k30", 32'(enable), 32'h02);
        at(173); check("a_done", 32'(frame_done), 32'h1);
        at(174); check("a_count", 32'(frame_count), 32'd1);
                 check("a_held", 32'(enable), 32'h10);
                 check("a_done_off", 32'(frame_done), 32'h0);
        at(180);

        // stage 2 waits on stage_ready[1] held low
        ready = 5'b11101;
        trigger();
        at(1054); check("b_te_early", 32'(timeout_err), 32'h0);
                  check("b_en_wait", 32'(enable), 32'h10);
        at(1055); check("b_te", 32'(timeout_err), 32'h1);
                  check("b_fault", 32'(stage_fault), 32'h04);
                  check("b_en_clr", 32'(enable), 32'h00);
                  check("b_count", 32'(frame_count), 32'd1);
        at(1056); check("b_te_off", 32'(timeout_err), 32'h0);
        ready = '1;
        at(1060);

        // counter parked at zero for four cycles
        cnt = '0;
        k0 = cyc;
        repeat (4) step();
        cnt = CW'(1);
        at(180); check("c_count", 32'(frame_count), 32'd2);

        // 100-cycle sampling period, sequence lasts 173 cycles
        k0 = cyc;
        for (int n = 0; n < 190; n++) begin
            if (n == 102) begin
                check("d_overrun", 32'(overrun), 32'h1);
                check("d_busy", 32'(busy), 32'h1);
            end
            if (n == 173) check("d_done", 32'(frame_done), 32'h1);
            cnt = ((n % 100) == 0) ? CW'(0) : CW'(n % 100);
            step();
        end
        cnt = CW'(1);
        at(260); check("d_count", 32'(frame_count), 32'd3);

        // run dropped in stage 3 delay
        trigger();
        at(60); run = 1'b0;
        step(); check("e_en_clr", 32'(enable), 32'h00);
                check("e_busy", 32'(busy), 32'h0);
        run = 1'b1;
        at(250); check("e_count", 32'(frame_count), 32'd3);
        trigger();
        at(175); check("e_count2", 32'(frame_count), 32'd4);
        at(180);

        // trigger lands on the DONE cycle
        trigger();
        at(173); check("f_done", 32'(frame_done), 32'h1);
                 check("f_count", 32'(frame_count), 32'd5);
                 check("f_busy_done", 32'(busy), 32'h1);
                 cnt = '0;
        step();  cnt = CW'(1);
                 check("f_busy_next", 32'(busy), 32'h1);
        step();  check("f_en0", 32'(enable), 32'h11);
        at(347); check("f_count2", 32'(frame_count), 32'd6);
        at(352);

        // reset during PULSE with held enable and sticky flags set
        trigger();
        at(2); check("g_pulse", 32'(enable), 32'h11);
               rst = 1'b1;
        step(); check("g_en", 32'(enable), 32'h0);
                check("g_busy", 32'(busy), 32'h0);
                check("g_sticky", {overrun, stage_fault}, 32'h0);
                check("g_count", 32'(frame_count), 32'h0);
        rst = 1'b0;
        step(); step();
        trigger();
        at(175); check("g_count2", 32'(frame_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
